// File: rtl/mul_pe_pkg.sv
// Shared constants, FSM encoding and helpers for the MUL_PE issue/return sequencer.
package mul_pe_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRun   = ST_RUN,
        StFlush = ST_FLUSH
    } state_e;

    // Bits needed to hold values 0..n-1 (at least 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Magnitude of the low w bits of x; -2^(w-1) maps to 2^(w-1), which still fits in w bits.
    function automatic logic [63:0] abs_mag(input logic [63:0] x, input int unsigned w,
                                            input logic is_signed);
        logic [63:0] mask;
        logic [5:0]  msb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = 6'(w - 1);
        if (is_signed && x[msb]) return (~x + 64'd1) & mask;
        return x & mask;
    endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// FD-deep synchronous product FIFO; push into a full FIFO is accepted only alongside a pop.
module mul_res_fifo
    import mul_pe_pkg::*;
#(
    parameter int unsigned FD = 4,
    parameter int unsigned W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic [clog2(FD + 1)-1:0]  cnt,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = clog2(FD);
    localparam int unsigned CW = clog2(FD + 1);

    logic [W-1:0]  mem_q [FD];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(FD));
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && (!full || pop) && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mul_pe_seq_ctrl.sv
// Issue/return sequencer for a DW-stage shift-add MUL_PE chain with credit-protected result FIFO.
// Optional MUL_PE_SEQ_PERF_EN adds a 32-bit perf_ops count of output handshakes.
module mul_pe_seq_ctrl
    import mul_pe_pkg::*;
#(
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned FD     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_a,
    input  logic [DW-1:0]     in_b,
    input  logic              flush,
    output logic              pe_en_synch,
    output logic              pe_en,
    output logic [2*DW-1:0]   pe_mul1,
    output logic [DW-1:0]     pe_mul2,
    output logic              pe_sign,
    input  logic [2*DW-1:0]   pe_result,
    input  logic              pe_result_flag,
    input  logic              pe_sign_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic              busy,
`ifdef MUL_PE_SEQ_PERF_EN
    output logic [31:0]       perf_ops,
`endif
    output logic              err
);

    localparam int unsigned CW = clog2(FD + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FD);

    state_e          state_q, state_d;
    logic [CW-1:0]   in_flight_q, in_flight_d;
    logic            err_q, err_d;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full, fifo_empty;
    logic [CW:0]     credit_used;
    logic            issue, res_seen, res_push, res_stray, pop, push_ovf;
    logic [2*DW-1:0] res_data;

    // Credit covers every product already issued or buffered, so the chain never needs to stall.
    assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_cnt};
    assign in_ready    = !flush && (state_q != StFlush) && (credit_used < CREDIT_MAX);
    assign issue       = in_valid && in_ready;

    assign pe_en       = issue;
    assign pe_en_synch = (state_q != StFlush);
    assign pe_mul1     = (2*DW)'(abs_mag(64'(in_a), DW, SIGNED != 0));
    assign pe_mul2     = DW'(abs_mag(64'(in_b), DW, SIGNED != 0));
    assign pe_sign     = (SIGNED != 0) && (in_a[DW-1] ^ in_b[DW-1]);

    // Results arriving during a flush belong to discarded operations.
    assign res_seen  = pe_result_flag && !flush && (state_q != StFlush);
    assign res_stray = res_seen && (in_flight_q == '0);
    assign res_push  = res_seen && (in_flight_q != '0);
    assign res_data  = pe_sign_out ? -pe_result : pe_result;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_ovf  = res_push && fifo_full && !pop;
    assign busy      = (in_flight_q != '0) || !fifo_empty;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        in_flight_d = in_flight_q;
        err_d       = err_q | res_stray | push_ovf;
        if (flush) begin
            state_d     = StFlush;
            in_flight_d = '0;
        end else begin
            case ({issue, res_push})
                2'b10:   in_flight_d = in_flight_q + CW'(1);
                2'b01:   in_flight_d = in_flight_q - CW'(1);
                default: in_flight_d = in_flight_q;
            endcase
            unique case (state_q)
                StIdle:  if (issue) state_d = StRun;
                StRun:   if (in_flight_d == '0) state_d = StIdle;
                StFlush: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_flight_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
        end
    end

    mul_res_fifo #(
        .FD (FD),
        .W  (2 * DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (res_push),
        .pop   (pop),
        .wdata (res_data),
        .rdata (out_data),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MUL_PE_SEQ_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;

    assign perf_ops_d = perf_ops_q + (pop ? 32'd1 : 32'd0);
    assign perf_ops   = perf_ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_ops_q <= '0;
        else        perf_ops_q <= perf_ops_d;
    end
`endif

endmodule

// File: tb/tb_mul_pe_seq_ctrl.sv
// Directed bench for mul_pe_seq_ctrl: two instances (FD=4, FD=16) each driving a behavioural MUL_PE chain.
module tb_mul_pe_seq_ctrl;

    localparam int unsigned DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, force_flag = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;

    logic        in_ready [2], pe_en_synch [2], pe_en [2], pe_sign [2];
    logic        pe_result_flag [2], pe_sign_out [2], out_valid [2], busy [2], err [2];
    logic [15:0] pe_mul1 [2], pe_result [2], out_data [2];
    logic [7:0]  pe_mul2 [2];
`ifdef MUL_PE_SEQ_PERF_EN
    logic [31:0] perf_ops [2];
`endif

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_pe_seq_ctrl #(.DW(DW), .SIGNED(1), .FD(4)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready[0]),
        .in_a (in_a), .in_b (in_b), .flush (flush), .pe_en_synch (pe_en_synch[0]),
        .pe_en (pe_en[0]), .pe_mul1 (pe_mul1[0]), .pe_mul2 (pe_mul2[0]), .pe_sign (pe_sign[0]),
        .pe_result (pe_result[0]), .pe_result_flag (pe_result_flag[0]),
        .pe_sign_out (pe_sign_out[0]), .out_valid (out_valid[0]), .out_ready (out_ready),
        .out_data (out_data[0]), .busy (busy[0]),
`ifdef MUL_PE_SEQ_PERF_EN
        .perf_ops (perf_ops[0]),
`endif
        .err (err[0])
    );

    mul_pe_seq_ctrl #(.DW(DW), .SIGNED(1), .FD(16)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready[1]),
        .in_a (in_a), .in_b (in_b), .flush (flush), .pe_en_synch (pe_en_synch[1]),
        .pe_en (pe_en[1]), .pe_mul1 (pe_mul1[1]), .pe_mul2 (pe_mul2[1]), .pe_sign (pe_sign[1]),
        .pe_result (pe_result[1]), .pe_result_flag (pe_result_flag[1]),
        .pe_sign_out (pe_sign_out[1]), .out_valid (out_valid[1]), .out_ready (out_ready),
        .out_data (out_data[1]), .busy (busy[1]),
`ifdef MUL_PE_SEQ_PERF_EN
        .perf_ops (perf_ops[1]),
`endif
        .err (err[1])
    );

    // Behavioural MUL_PE chain: DW register stages, cleared by reset or pe_en_synch=0.
    logic [15:0] ch_p [2][DW];
    logic        ch_v [2][DW];
    logic        ch_s [2][DW];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !pe_en_synch[i]) begin
                for (int s = 0; s < DW; s++) begin
                    ch_p[i][s] <= '0;
                    ch_v[i][s] <= 1'b0;
                    ch_s[i][s] <= 1'b0;
                end
            end else begin
                for (int s = 1; s < DW; s++) begin
                    ch_p[i][s] <= ch_p[i][s-1];
                    ch_v[i][s] <= ch_v[i][s-1];
                    ch_s[i][s] <= ch_s[i][s-1];
                end
                ch_p[i][0] <= pe_mul1[i] * {8'h00, pe_mul2[i]};
                ch_v[i][0] <= pe_en[i];
                ch_s[i][0] <= pe_sign[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pe_result[i]      = ch_p[i][DW-1];
            pe_result_flag[i] = ch_v[i][DW-1] | force_flag;
            pe_sign_out[i]    = ch_s[i][DW-1];
        end
    end

    // Output collector: records every completed out handshake.
    logic [15:0] got0 [$];
    logic [15:0] got1 [$];
    int          gcyc1 [$];

    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_ready) begin
            if (out_valid[0]) got0.push_back(out_data[0]);
            if (out_valid[1]) begin
                got1.push_back(out_data[1]);
                gcyc1.push_back(cyc);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] vec_a(input int i);
        return 8'(i * 29 - 100);
    endfunction

    function automatic logic [7:0] vec_b(input int i);
        return 8'(50 - i * 13);
    endfunction

    function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 16'(p);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; force_flag = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        got0.delete(); got1.delete(); gcyc1.delete();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int lat, mism, drops, acc, first_drop;
        logic [15:0] data;

        // Reset state
        do_reset();
        check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check_eq("rst_pe_en_synch", 32'(pe_en_synch[0]), 32'd1);
        check_eq("rst_pe_en", 32'(pe_en[0]), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_err", 32'(err[0]), 32'd0);

        // Single op: -3 * 5
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFD; in_b = 8'h05;
        #1;
        check_eq("single_pe_en", 32'(pe_en[0]), 32'd1);
        check_eq("single_mul1", 32'(pe_mul1[0]), 32'd3);
        check_eq("single_mul2", 32'(pe_mul2[0]), 32'd5);
        check_eq("single_sign", 32'(pe_sign[0]), 32'd1);
        lat = 0; data = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (k == 1) check_eq("single_busy", 32'(busy[0]), 32'd1);
            if (out_valid[0] && lat == 0) begin
                lat = k;
                data = out_data[0];
            end
        end
        check_eq("single_latency", 32'(lat), 32'd9);
        check_eq("single_data", 32'(data), 32'h0000FFF1);

        // Corners: -128 * -128 and 0 * -7
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h80; in_b = 8'h80;
        #1;
        check_eq("corner_mul1_min", 32'(pe_mul1[0]), 32'h80);
        check_eq("corner_mul2_min", 32'(pe_mul2[0]), 32'h80);
        check_eq("corner_sign_min", 32'(pe_sign[0]), 32'd0);
        @(negedge clk);
        in_a = 8'h00; in_b = 8'hF9;
        #1;
        check_eq("corner_mul2_neg7", 32'(pe_mul2[0]), 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check_eq("corner_count", 32'(got0.size()), 32'd2);
        check_eq("corner_min_prod", 32'(got0[0]), 32'h4000);
        check_eq("corner_zero_prod", 32'(got0[1]), 32'd0);

        // 16 back-to-back ops on the FD=16 instance
        do_reset();
        out_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vec_a(i); in_b = vec_b(i);
            #1;
            if (!in_ready[1]) drops++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check_eq("b2b_ready_drops", 32'(drops), 32'd0);
        check_eq("b2b_count", 32'(got1.size()), 32'd16);
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= got1.size() || got1[i] !== exp_prod(vec_a(i), vec_b(i))) mism++;
        end
        check_eq("b2b_order_data", 32'(mism), 32'd0);
        check_eq("b2b_one_per_cycle", 32'(gcyc1.size() == 16 ? gcyc1[15] - gcyc1[0] : -1), 32'd15);
        check_eq("b2b_err", 32'(err[1]), 32'd0);

        // Credit limit on the FD=4 instance with a stalled consumer
        do_reset();
        out_ready = 1'b0;
        acc = 0; first_drop = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = vec_a(i); in_b = vec_b(i);
            #1;
            if (in_ready[0]) acc++;
            else if (first_drop < 0) first_drop = i;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check_eq("credit_accepted", 32'(acc), 32'd4);
        check_eq("credit_first_drop", 32'(first_drop), 32'd4);
        check_eq("credit_full_ready", 32'(in_ready[0]), 32'd0);
        check_eq("credit_full_valid", 32'(out_valid[0]), 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check_eq("credit_count", 32'(got0.size()), 32'd4);
        mism = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= got0.size() || got0[i] !== exp_prod(vec_a(i), vec_b(i))) mism++;
        end
        check_eq("credit_data", 32'(mism), 32'd0);
        check_eq("credit_err", 32'(err[0]), 32'd0);
        check_eq("credit_busy_after", 32'(busy[0]), 32'd0);
        check_eq("credit_ready_after", 32'(in_ready[0]), 32'd1);

        // Flush at issue+3 with two ops in flight; flush beats a concurrent in_valid
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h03;
        @(negedge clk);
        in_a = 8'hF0; in_b = 8'h04;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_a = 8'h05; in_b = 8'h05;
        #1;
        check_eq("flush_no_issue", 32'(pe_en[0]), 32'd0);
        check_eq("flush_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("flush_synch_low", 32'(pe_en_synch[0]), 32'd0);
        check_eq("flush_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        #1;
        check_eq("flush_synch_back", 32'(pe_en_synch[0]), 32'd1);
        repeat (12) @(negedge clk);
        #1;
        check_eq("flush_no_output", 32'(got0.size()), 32'd0);
        check_eq("flush_err", 32'(err[0]), 32'd0);
        check_eq("flush_busy_end", 32'(busy[0]), 32'd0);

        // Stray result flag with nothing in flight
        do_reset();
        @(negedge clk);
        force_flag = 1'b1;
        @(negedge clk);
        force_flag = 1'b0;
        #1;
        check_eq("stray_err", 32'(err[0]), 32'd1);
        check_eq("stray_no_push", 32'(out_valid[0]), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("stray_err_sticky", 32'(err[0]), 32'd1);
        do_reset();
        check_eq("stray_err_reset", 32'(err[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
